// File: rtl/mer_meas_ctrl_pkg.sv
// Shared types and defaults for the MER measurement sequencer.
// State encodings are shared so the top and any debug logic agree.
package mer_meas_ctrl_pkg;

    localparam int ACC_W_DEFAULT = 40;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_HOLD   = 3'd4
    } meas_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mer_meas_ctrl_sym_window_counter.sv
// Loadable symbol-rate down-counter; terminal is high while the count sits at zero.
// A load value of N-1 therefore spans exactly N symbols before the terminal enable.
module sym_window_counter #(
    parameter int W = 20
) (
    input  logic         sys_clk,
    input  logic         reset,
    input  logic         sym_clk_ena,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         terminal
);

    logic [W-1:0] count;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (sym_clk_ena && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign terminal = (count == '0);

endmodule

// File: rtl/mer_meas_ctrl.sv
// MER measurement sequencer: clear, settle, window count, hold and result latch.
// clear_acc/hold_acc are registered so they stay constant for whole symbols.
module mer_meas_ctrl
    import mer_meas_ctrl_pkg::*;
#(
    parameter int WIN_LOG2    = 20,
    parameter int SETTLE_SYMS = 8,
    parameter int ACC_W       = ACC_W_DEFAULT,
    parameter int CNT_W       = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             sym_clk_ena,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    input  logic [ACC_W-1:0] acc_sq_in,
    input  logic [ACC_W-1:0] acc_dc_in,
    input  logic             res_ack,
    output logic             clear_acc,
    output logic             hold_acc,
    output logic             busy,
    output logic             res_valid,
    output logic [ACC_W-1:0] sq_result,
    output logic [ACC_W-1:0] dc_result,
    output logic [CNT_W-1:0] meas_count,
    output logic             overrun
);

    localparam int CW = max_int(WIN_LOG2, $clog2(SETTLE_SYMS + 1));
    localparam logic [CW-1:0] WIN_LOAD    = CW'((64'd1 << WIN_LOG2) - 64'd1);
    localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE_SYMS > 0) ? CW'(SETTLE_SYMS - 1) : '0;

    meas_state_t   state;
    meas_state_t   next_state;
    logic          start_pend;
    logic          go;
    logic          state_adv;
    logic          win_done;
    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          clear_d;
    logic          hold_d;
    logic          latch;

    assign go        = start_pend | start;
    assign state_adv = sym_clk_ena | abort;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            clear_acc <= 1'b0;
            hold_acc  <= 1'b1;
        end else if (state_adv) begin
            state     <= next_state;
            clear_acc <= clear_d;
            hold_acc  <= hold_d;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = ST_IDLE;
        end else if (sym_clk_ena) begin
            case (state)
                ST_IDLE:   if (go) next_state = ST_CLEAR;
                ST_CLEAR:  next_state = (SETTLE_SYMS == 0) ? ST_ACCUM : ST_SETTLE;
                ST_SETTLE: if (win_done) next_state = ST_ACCUM;
                ST_ACCUM:  if (win_done) next_state = ST_HOLD;
                ST_HOLD:   next_state = continuous ? ST_CLEAR : ST_IDLE;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    // Strobe values and counter reloads are derived from the state being entered.
    always_comb begin
        clear_d      = (next_state == ST_CLEAR);
        hold_d       = (next_state == ST_IDLE) || (next_state == ST_HOLD);
        cnt_load     = state_adv && (next_state != state);
        cnt_load_val = '0;
        case (next_state)
            ST_SETTLE: cnt_load_val = SETTLE_LOAD;
            ST_ACCUM:  cnt_load_val = WIN_LOAD;
            default:   cnt_load_val = '0;
        endcase
        latch = sym_clk_ena && !abort && (state == ST_HOLD);
    end

    sym_window_counter #(.W(CW)) u_win_cnt (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .sym_clk_ena (sym_clk_ena),
        .load        (cnt_load),
        .load_val    (cnt_load_val),
        .terminal    (win_done)
    );

    // Starts are only remembered while idle; a start during a run is dropped.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            start_pend <= 1'b0;
        end else if (abort || (state != ST_IDLE) || sym_clk_ena) begin
            start_pend <= 1'b0;
        end else if (start) begin
            start_pend <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sq_result  <= '0;
            dc_result  <= '0;
            res_valid  <= 1'b0;
            meas_count <= '0;
            overrun    <= 1'b0;
        end else if (latch) begin
            sq_result  <= acc_sq_in;
            dc_result  <= acc_dc_in;
            res_valid  <= 1'b1;
            meas_count <= meas_count + 1'b1;
            if (res_valid && !res_ack) begin
                overrun <= 1'b1;
            end
        end else if (res_ack && res_valid) begin
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mer_meas_ctrl.sv
// Bench for mer_meas_ctrl: directed vector table plus randomized run against a
// symbol-position reference model (WIN_LOG2=4, SETTLE_SYMS=2, enable every 4 clocks).
module tb_mer_meas_ctrl;

    localparam int WIN_LOG2    = 4;
    localparam int SETTLE_SYMS = 2;
    localparam int ACC_W       = 40;
    localparam int CNT_W       = 16;
    localparam int TOTAL       = 1 + SETTLE_SYMS + (1 << WIN_LOG2) + 1;

    logic             sys_clk;
    logic             reset;
    logic             sym_clk_ena;
    logic             start;
    logic             continuous;
    logic             abort;
    logic [ACC_W-1:0] acc_sq_in;
    logic [ACC_W-1:0] acc_dc_in;
    logic             res_ack;
    logic             clear_acc;
    logic             hold_acc;
    logic             busy;
    logic             res_valid;
    logic [ACC_W-1:0] sq_result;
    logic [ACC_W-1:0] dc_result;
    logic [CNT_W-1:0] meas_count;
    logic             overrun;

    mer_meas_ctrl #(
        .WIN_LOG2    (WIN_LOG2),
        .SETTLE_SYMS (SETTLE_SYMS),
        .ACC_W       (ACC_W),
        .CNT_W       (CNT_W)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .sym_clk_ena (sym_clk_ena),
        .start       (start),
        .continuous  (continuous),
        .abort       (abort),
        .acc_sq_in   (acc_sq_in),
        .acc_dc_in   (acc_dc_in),
        .res_ack     (res_ack),
        .clear_acc   (clear_acc),
        .hold_acc    (hold_acc),
        .busy        (busy),
        .res_valid   (res_valid),
        .sq_result   (sq_result),
        .dc_result   (dc_result),
        .meas_count  (meas_count),
        .overrun     (overrun)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic             start;
        logic             abort;
        logic             cont;
        logic             ack;
        logic [ACC_W-1:0] sq;
        int               ncyc;
        logic             e_clr;
        logic             e_hold;
        logic             e_busy;
        logic             e_rv;
        logic             e_ov;
        int               e_cnt;
        logic [ACC_W-1:0] e_sq;
    } vec_t;

    vec_t tbl[26];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: measurement is "active" and at symbol position m_pos of TOTAL.
    bit               m_active;
    int               m_pos;
    bit               m_pend;
    bit               m_rv;
    bit               m_ov;
    int               m_cnt;
    logic [ACC_W-1:0] m_sq;
    logic [ACC_W-1:0] m_dc;

    function automatic vec_t mk(input logic st, input logic ab, input logic ct, input logic ak,
                                input logic [ACC_W-1:0] sq, input int n,
                                input logic ec, input logic eh, input logic eb, input logic erv,
                                input logic eov, input int ecnt, input logic [ACC_W-1:0] esq);
        vec_t v;
        v.start = st;  v.abort = ab; v.cont = ct; v.ack = ak; v.sq = sq; v.ncyc = n;
        v.e_clr = ec;  v.e_hold = eh; v.e_busy = eb; v.e_rv = erv; v.e_ov = eov;
        v.e_cnt = ecnt; v.e_sq = esq;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_pend = 0; m_rv = 0; m_ov = 0; m_cnt = 0;
        m_sq = '0; m_dc = '0;
    endtask

    task automatic model_update();
        bit latch_now;
        latch_now = 0;
        if (abort) begin
            m_active = 0;
            m_pend   = 0;
        end else if (!m_active) begin
            if (sym_clk_ena && (m_pend || start)) begin
                m_active = 1;
                m_pos    = 0;
                m_pend   = 0;
            end else if (start) begin
                m_pend = 1;
            end
        end else if (sym_clk_ena) begin
            if (m_pos == TOTAL - 1) begin
                latch_now = 1;
                if (continuous) m_pos = 0;
                else m_active = 0;
            end else begin
                m_pos++;
            end
        end
        if (latch_now) begin
            if (m_rv && !res_ack) m_ov = 1;
            m_rv  = 1;
            m_sq  = acc_sq_in;
            m_dc  = acc_dc_in;
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end else if (res_ack && m_rv) begin
            m_rv = 0;
            m_ov = 0;
        end
    endtask

    task automatic compare_model();
        check_output("model clear_acc", 64'(clear_acc), 64'(m_active && (m_pos == 0)));
        check_output("model hold_acc", 64'(hold_acc), 64'(!m_active || (m_pos == TOTAL - 1)));
        check_output("model busy", 64'(busy), 64'(m_active));
        check_output("model res_valid", 64'(res_valid), 64'(m_rv));
        check_output("model overrun", 64'(overrun), 64'(m_ov));
        check_output("model meas_count", 64'(meas_count), 64'(m_cnt));
        check_output("model sq_result", 64'(sq_result), 64'(m_sq));
        check_output("model dc_result", 64'(dc_result), 64'(m_dc));
    endtask

    task automatic step();
        sym_clk_ena = (cyc % 4 == 3);
        @(posedge sys_clk);
        model_update();
        cyc++;
        @(negedge sys_clk);
        compare_model();
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " hold_acc"}, 64'(hold_acc), 64'd1);
        check_output({tag, " clear_acc"}, 64'(clear_acc), 64'd0);
        check_output({tag, " busy"}, 64'(busy), 64'd0);
        check_output({tag, " res_valid"}, 64'(res_valid), 64'd0);
        check_output({tag, " overrun"}, 64'(overrun), 64'd0);
        check_output({tag, " meas_count"}, 64'(meas_count), 64'd0);
        check_output({tag, " sq_result"}, 64'(sq_result), 64'd0);
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        string tag;
        for (int c = 0; c < v.ncyc; c++) begin
            start      = (c == 0) && v.start;
            abort      = (c == 0) && v.abort;
            res_ack    = (c == 0) && v.ack;
            continuous = v.cont;
            acc_sq_in  = v.sq;
            acc_dc_in  = {v.sq[ACC_W-5:0], 4'h5};
            step();
        end
        start = 0; abort = 0; res_ack = 0;
        tag = $sformatf("vec%0d", idx);
        check_output({tag, " clear_acc"}, 64'(clear_acc), 64'(v.e_clr));
        check_output({tag, " hold_acc"}, 64'(hold_acc), 64'(v.e_hold));
        check_output({tag, " busy"}, 64'(busy), 64'(v.e_busy));
        check_output({tag, " res_valid"}, 64'(res_valid), 64'(v.e_rv));
        check_output({tag, " overrun"}, 64'(overrun), 64'(v.e_ov));
        check_output({tag, " meas_count"}, 64'(meas_count), 64'(v.e_cnt));
        check_output({tag, " sq_result"}, 64'(sq_result), 64'(v.e_sq));
    endtask

    initial begin
        tbl[0]  = mk(1,0,0,0,40'h123, 1, 0,1,0,0,0,0,40'h0);
        tbl[1]  = mk(0,0,0,0,40'h123, 3, 1,0,1,0,0,0,40'h0);
        tbl[2]  = mk(0,0,0,0,40'h123, 4, 0,0,1,0,0,0,40'h0);
        tbl[3]  = mk(0,0,0,0,40'h123, 8, 0,0,1,0,0,0,40'h0);
        tbl[4]  = mk(0,0,0,0,40'h123,60, 0,0,1,0,0,0,40'h0);
        tbl[5]  = mk(0,0,0,0,40'h123, 4, 0,1,1,0,0,0,40'h0);
        tbl[6]  = mk(0,0,0,0,40'h123, 4, 0,1,0,1,0,1,40'h123);
        tbl[7]  = mk(0,0,0,1,40'h123, 1, 0,1,0,0,0,1,40'h123);
        tbl[8]  = mk(1,0,1,0,40'h456, 3, 1,0,1,0,0,1,40'h123);
        tbl[9]  = mk(0,0,1,0,40'h456,80, 1,0,1,1,0,2,40'h456);
        tbl[10] = mk(0,0,1,0,40'h789,80, 1,0,1,1,1,3,40'h789);
        tbl[11] = mk(0,0,0,1,40'hABC, 1, 1,0,1,0,0,3,40'h789);
        tbl[12] = mk(0,0,0,0,40'hABC,80, 0,1,0,1,0,4,40'hABC);
        tbl[13] = mk(0,0,0,1,40'hABC, 1, 0,1,0,0,0,4,40'hABC);
        tbl[14] = mk(1,0,0,0,40'hDEF, 2, 1,0,1,0,0,4,40'hABC);
        tbl[15] = mk(0,0,0,0,40'hDEF,38, 0,0,1,0,0,4,40'hABC);
        tbl[16] = mk(0,1,0,0,40'hDEF, 1, 0,1,0,0,0,4,40'hABC);
        tbl[17] = mk(0,0,0,0,40'hDEF, 8, 0,1,0,0,0,4,40'hABC);
        tbl[18] = mk(1,1,0,0,40'hDEF, 9, 0,1,0,0,0,4,40'hABC);
        tbl[19] = mk(1,0,0,0,40'h111, 4, 1,0,1,0,0,4,40'hABC);
        tbl[20] = mk(1,0,0,0,40'h111,40, 0,0,1,0,0,4,40'hABC);
        tbl[21] = mk(0,0,0,0,40'h111,40, 0,1,0,1,0,5,40'h111);
        tbl[22] = mk(0,0,0,0,40'h111,20, 0,1,0,1,0,5,40'h111);
        tbl[23] = mk(1,0,0,0,40'h222, 4, 1,0,1,1,0,5,40'h111);
        tbl[24] = mk(0,0,0,0,40'h222,79, 0,1,1,1,0,5,40'h111);
        tbl[25] = mk(0,0,0,1,40'h222, 1, 0,1,0,1,0,6,40'h222);

        reset = 1; sym_clk_ena = 0; start = 0; continuous = 0; abort = 0;
        acc_sq_in = '0; acc_dc_in = '0; res_ack = 0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        check_reset_values("reset");
        reset = 0;
        cyc = 0;

        for (int i = 0; i < 26; i++) begin
            apply_stimulus(tbl[i], i);
        end

        for (int i = 0; i < 3000; i++) begin
            start      = ($urandom_range(0, 29) == 0);
            abort      = ($urandom_range(0, 249) == 0);
            res_ack    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) continuous = ~continuous;
            acc_sq_in  = {$urandom(), $urandom()};
            acc_dc_in  = {$urandom(), $urandom()};
            step();
            if (i == 1530) begin
                #2 reset = 1;
                #1 check_reset_values("async reset");
                model_reset();
                @(negedge sys_clk);
                reset = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
